// File: rtl/axi_stream_slack_fifo_if.sv
// AXI stream bundle shared by the slack FIFO and its neighbours.
// The master drives payload and valid; the slave answers with ready.
interface axi_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
    logic                  tlast;
    logic                  valid;
    logic                  ready;

    modport master (output data, output dest, output user, output tlast, output valid,
                    input ready);
    modport slave  (input data, input dest, input user, input tlast, input valid,
                    output ready);
endinterface

// File: rtl/axi_stream_slack_fifo.sv
// First-word-fall-through stream FIFO behind a registered-ready upstream stage.
// Every valid beat is taken while space exists; ready drops early to leave SLACK headroom.
module axi_stream_slack_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned SLACK      = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear_overflow,
    axi_stream.slave                     stream_in,
    axi_stream.master                    stream_out,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         overflow
);
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned EntryW = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    logic [EntryW-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              r_overflow;
    logic              r_ready;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CntW-1:0]   w_count_next;

    assign w_full = (r_count == CntW'(DEPTH));
    assign w_pop  = (r_count != '0) && stream_out.ready;
    // Incoming ready is only a hint: acceptance depends on space alone.
    assign w_push = stream_in.valid && (!w_full || w_pop);
    assign w_drop = stream_in.valid && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= w_count_next;
            // A drop in the same cycle as a clear must leave the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
            r_ready <= (w_count_next < CntW'(DEPTH - SLACK));
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {stream_in.data, stream_in.dest, stream_in.user, stream_in.tlast};
        end
    end

    assign stream_in.ready  = r_ready;
    assign stream_out.valid = (r_count != '0);
    assign {stream_out.data, stream_out.dest, stream_out.user, stream_out.tlast} =
        r_mem[r_rd_ptr];
    assign occupancy = r_count;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_axi_stream_slack_fifo.sv
// Directed bench for the slack FIFO at DEPTH=8, SLACK=2: vector table plus
// hand-written streaming, random backpressure and mid-stream reset sequences.
module tb_axi_stream_slack_fifo;
    localparam int unsigned DW = 16;
    localparam int unsigned EW = 8;
    localparam int unsigned UW = 8;

    logic       clock;
    logic       reset;
    logic       clear_overflow;
    logic [3:0] occupancy;
    logic       overflow;

    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) s_in ();
    axi_stream #(.DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW)) s_out ();

    axi_stream_slack_fifo #(
        .DATA_WIDTH(DW), .DEST_WIDTH(EW), .USER_WIDTH(UW), .DEPTH(8), .SLACK(2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear_overflow (clear_overflow),
        .stream_in      (s_in),
        .stream_out     (s_out),
        .occupancy      (occupancy),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [15:0] din;
        logic        rdy;
        logic        clr;
        logic        exp_v;
        logic [15:0] exp_d;
        logic [3:0]  exp_occ;
        logic        exp_rdy;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    // Sideband fields are derived from data so each beat is self-describing.
    function automatic logic [7:0] dest_of(input logic [15:0] d);
        return d[7:0] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] user_of(input logic [15:0] d);
        return d[15:8] + d[7:0] + 8'h11;
    endfunction
    function automatic logic tlast_of(input logic [15:0] d);
        return ^d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [15:0] d, input logic rdy,
                         input logic clr);
        s_in.valid     = vld;
        s_in.data      = d;
        s_in.dest      = dest_of(d);
        s_in.user      = user_of(d);
        s_in.tlast     = tlast_of(d);
        s_out.ready    = rdy;
        clear_overflow = clr;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_head(input string name, input logic [15:0] d);
        check({name, ".data"}, 32'(s_out.data), 32'(d));
        check({name, ".dest"}, 32'(s_out.dest), 32'(dest_of(d)));
        check({name, ".user"}, 32'(s_out.user), 32'(user_of(d)));
        check({name, ".tlast"}, 32'(s_out.tlast), 32'(tlast_of(d)));
    endtask

    function automatic vec_t mk(logic vld, logic [15:0] din, logic rdy, logic clr,
                                logic ev, logic [15:0] ed, logic [3:0] eo, logic er,
                                logic ef);
        vec_t v;
        v.vld = vld; v.din = din; v.rdy = rdy; v.clr = clr;
        v.exp_v = ev; v.exp_d = ed; v.exp_occ = eo; v.exp_rdy = er; v.exp_ovf = ef;
        return v;
    endfunction

    logic [15:0] q[$];
    logic [15:0] held_d;
    logic [7:0]  held_dest;
    logic [7:0]  held_user;
    logic        held_last;
    logic        held;
    logic        snd;
    logic        rr;
    int          sent;
    int          recvd;
    int          cyc;

    initial begin
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        check("rst.occ", 32'(occupancy), 32'd0);
        check("rst.valid", 32'(s_out.valid), 32'd0);
        check("rst.ready", 32'(s_in.ready), 32'd0);
        check("rst.ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        step();
        check("rel.ready", 32'(s_in.ready), 32'd1);
        check("rel.occ", 32'(occupancy), 32'd0);

        // vld din rdy clr | valid head occ ready ovf
        vecs.push_back(mk(1, 16'h0001, 0, 0, 1, 16'h0001, 4'd1, 1, 0));
        vecs.push_back(mk(1, 16'h0002, 0, 0, 1, 16'h0001, 4'd2, 1, 0));
        vecs.push_back(mk(1, 16'h0003, 0, 0, 1, 16'h0001, 4'd3, 1, 0));
        vecs.push_back(mk(1, 16'h0004, 0, 0, 1, 16'h0001, 4'd4, 1, 0));
        vecs.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0001, 4'd5, 1, 0));
        vecs.push_back(mk(1, 16'h0006, 0, 0, 1, 16'h0001, 4'd6, 0, 0));
        vecs.push_back(mk(1, 16'h0007, 0, 0, 1, 16'h0001, 4'd7, 0, 0));
        vecs.push_back(mk(1, 16'h0008, 0, 0, 1, 16'h0001, 4'd8, 0, 0));
        vecs.push_back(mk(1, 16'h00AA, 1, 0, 1, 16'h0002, 4'd8, 0, 0));
        vecs.push_back(mk(1, 16'h00B1, 0, 0, 1, 16'h0002, 4'd8, 0, 1));
        vecs.push_back(mk(1, 16'h00B2, 0, 0, 1, 16'h0002, 4'd8, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0002, 4'd8, 0, 0));
        vecs.push_back(mk(1, 16'h00B3, 0, 1, 1, 16'h0002, 4'd8, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0002, 4'd8, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0002, 4'd8, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0003, 4'd7, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0004, 4'd6, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0005, 4'd5, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0006, 4'd4, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0007, 4'd3, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0008, 4'd2, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h00AA, 4'd1, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 4'd0, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            step();
            check($sformatf("vec%0d.valid", i), 32'(s_out.valid), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d.occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
            check($sformatf("vec%0d.ready", i), 32'(s_in.ready), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_v) check_head($sformatf("vec%0d", i), vecs[i].exp_d);
        end

        // Streaming: one beat in and one out per cycle, occupancy pinned at 1.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
            step();
            check("stream.valid", 32'(s_out.valid), 32'd1);
            check("stream.occ", 32'(occupancy), 32'd1);
            check_head("stream", 16'h0100 + 16'(i));
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        check("stream_end.valid", 32'(s_out.valid), 32'd0);

        // Random backpressure; the producer honours ready so nothing may drop.
        sent = 0; recvd = 0; cyc = 0; held = 1'b0;
        held_d = '0; held_dest = '0; held_user = '0; held_last = 1'b0;
        while ((sent < 200 || recvd < 200) && cyc < 5000) begin
            if (held) begin
                check("bp.hold_valid", 32'(s_out.valid), 32'd1);
                check("bp.hold_data", 32'(s_out.data), 32'(held_d));
                check("bp.hold_dest", 32'(s_out.dest), 32'(held_dest));
                check("bp.hold_user", 32'(s_out.user), 32'(held_user));
                check("bp.hold_last", 32'(s_out.tlast), 32'(held_last));
            end
            snd = (sent < 200) && s_in.ready && ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            drive(snd, 16'h2000 + 16'(sent), rr, 1'b0);
            held = 1'b0;
            if (s_out.valid && rr) begin
                if (q.size() == 0) begin
                    check("bp.unexpected_beat", 32'(s_out.data), 32'hDEAD);
                end else begin
                    check_head("bp.pop", q.pop_front());
                    recvd++;
                end
            end else if (s_out.valid) begin
                held = 1'b1;
                held_d = s_out.data; held_dest = s_out.dest;
                held_user = s_out.user; held_last = s_out.tlast;
            end
            if (snd) begin
                q.push_back(16'h2000 + 16'(sent));
                sent++;
            end
            step();
            cyc++;
        end
        check("bp.timeout", 32'(cyc < 5000), 32'd1);
        check("bp.ovf", 32'(overflow), 32'd0);

        // Mid-operation reset with overflow set and 5 beats buffered.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        check("pre_rst.occ", 32'(occupancy), 32'd5);
        check("pre_rst.ovf", 32'(overflow), 32'd1);
        check_head("pre_rst", 16'h0303);
        reset = 1'b0;
        step();
        check("mid_rst.occ", 32'(occupancy), 32'd0);
        check("mid_rst.valid", 32'(s_out.valid), 32'd0);
        check("mid_rst.ready", 32'(s_in.ready), 32'd0);
        check("mid_rst.ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        step();
        check("post_rst.ready", 32'(s_in.ready), 32'd1);
        check("post_rst.valid", 32'(s_out.valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_stream_slack_fifo.md
Name: axi_stream_slack_fifo

Overview:
- Downstream buffer stage for the registered-ready AXI stream muxes (e.g. the 6-way mux).
- The upstream stage forwards valid regardless of ready, and its ready lags by one or more cycles. This FIFO therefore accepts every valid beat while it has space.
- It deasserts its registered ready early, keeping SLACK entries of headroom for in-flight beats.
- It presents a first-word-fall-through master stream to the consumer and flags any beat lost to overflow.

Parameters:
DATA_WIDTH, 16, width of data field
DEST_WIDTH, 8, width of dest field
USER_WIDTH, 8, width of user field
DEPTH, 16, number of entries (power of two, >= 4)
SLACK, 2, entries reserved for beats arriving after ready deasserts (1 <= SLACK < DEPTH)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
clear_overflow  input  1  synchronous clear of overflow flag
stream_in  axi_stream.slave  data/dest/user/tlast/valid/ready  upstream stream; ready is a registered backpressure hint
stream_out  axi_stream.master  data/dest/user/tlast/valid/ready  downstream FWFT stream
occupancy  output  $clog2(DEPTH+1)  registered entry count
overflow  output  1  sticky: a beat was dropped because the FIFO was full

Behaviour:
- Interface is fixed: one clock (clock); reset is synchronous and active-low (reset low = reset asserted).
- Entry format: {data, dest, user, tlast}, stored in a register array indexed by wr_ptr/rd_ptr. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Reset (reset==0 at clock edge):
  - wr_ptr=0, rd_ptr=0, occupancy=0, overflow=0.
  - stream_in.ready=0, stream_out.valid=0.
  - Storage contents need not be reset. stream_out data/dest/user/tlast read as don't-care while valid=0.
- push = stream_in.valid && (occupancy<DEPTH || pop).
  - stream_in.ready is NOT a qualifier for acceptance.
  - A valid beat is accepted whether or not ready is high, as long as space exists.
- pop = stream_out.valid && stream_out.ready.
- drop = stream_in.valid && occupancy==DEPTH && !pop. On drop: beat discarded, overflow<=1.
- overflow stays set until reset or clear_overflow=1. If clear_overflow and drop occur in the same cycle, set wins.
- occupancy_next = occupancy + push - pop. Simultaneous push and pop leaves the count unchanged, including at full and at 1.
- stream_out.valid = (occupancy!=0), decoded from the registered count.
- stream_out fields = storage[rd_ptr]. There is no combinational path from stream_in.* to stream_out.*.
- Latency: a beat pushed at edge N is visible on stream_out in the cycle following edge N.
  - Empty FIFO: valid rises one cycle after in.valid is sampled.
- FWFT: the head is held stable while stream_out.valid && !stream_out.ready (AXI stability rule).
- stream_in.ready is registered: ready <= (occupancy_next < DEPTH-SLACK).
  - Example: DEPTH=16, SLACK=2 → ready drops on the edge where occupancy_next reaches 14, and reasserts on the edge where it falls to 13.
- Empty and pop: impossible, since valid=0.
- Full, push, no pop: drop as above.
- Reset mid-stream: all buffered beats are discarded. The output shows valid=0 in the cycle after the reset edge.
- In the first cycle after reset deasserts, ready becomes 1 at the next edge, since occupancy 0 < DEPTH-SLACK.

Test Plan:
- Fill then drain (DEPTH=8, SLACK=2):
  - Stimulus: push 8 beats data=1..8 with out.ready=0, then raise out.ready.
  - Required: ready falls on the edge where occupancy_next=6; occupancy reaches 8; overflow stays 0; out emits 1..8 in order with tlast preserved; valid=0 after beat 8.
- Streaming:
  - Stimulus: continuous in.valid with out.ready=1, data incrementing from 0x100.
  - Required: out.valid high from the second cycle; one beat per cycle; occupancy constant at 1; no gaps; data matches input.
- Full with simultaneous push/pop:
  - Stimulus: at occupancy=8, assert in.valid (data=0xAA) and out.ready for one cycle.
  - Required: head popped, 0xAA accepted, occupancy stays 8, overflow=0.
- Overflow:
  - Stimulus: at occupancy=8, in.valid with out.ready=0 for 2 cycles (0xB1, 0xB2).
  - Required: both dropped; overflow=1 and stays 1. After clear_overflow pulse, overflow=0; a simultaneous drop+clear keeps it 1.
- Backpressure stability:
  - Stimulus: out.ready toggled randomly for 200 beats with dest/user varying.
  - Required: head fields stable while valid&&!ready; every beat delivered exactly once in order.
- Reset mid-operation:
  - Stimulus: occupancy=5, then reset=0 for 1 cycle.
  - Required: next cycle occupancy=0, out.valid=0, in.ready=0, overflow=0; ready=1 one edge after reset releases.
